delta_reg_bank: RTL and testbench

- Multi-channel bank of read-only change-detect ("delta") status registers for the control/status register file.
- Each channel samples a hardware value every cycle and detects changes under a per-channel mode: any bit, rising, falling or disabled.
- Each channel latches a sticky flag and a saturating change counter until software reads that channel; the read clears both.
- Masked flags are aggregated into one level interrupt toward the host CSR block.

---
 rtl/delta_reg_bank_pkg.sv | 30 +++
 rtl/delta_channel.sv | 101 ++++++++++
 rtl/delta_reg_bank.sv | 157 +++++++++++++++
 tb/tb_delta_reg_bank.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/delta_reg_bank_pkg.sv
// delta_reg_bank_pkg
// Shared types and helpers for the delta (change-detect) status register bank.
//   mode_t         : per-channel detect mode encoding (any / rise / fall / off)
//   detect_event() : turns per-channel change summaries into an event bit for a mode
// Related build option: DELTA_REG_BANK_SNAPSHOT_EN (see delta_reg_bank.sv).
package delta_reg_bank_pkg;

    typedef enum logic [1:0] {
        MODE_ANY  = 2'b00,
        MODE_RISE = 2'b01,
        MODE_FALL = 2'b10,
        MODE_OFF  = 2'b11
    } mode_t;

    // Reductions are done by the caller so the helper stays width-independent.
    function automatic logic detect_event(input mode_t mode,
                                          input logic  any_chg,
                                          input logic  any_rise,
                                          input logic  any_fall);
        logic ev;
        case (mode)
            MODE_ANY:  ev = any_chg;
            MODE_RISE: ev = any_rise;
            MODE_FALL: ev = any_fall;
            default:   ev = 1'b0;
        endcase
        return ev;
    endfunction

endpackage

// File: rtl/delta_channel.sv
// delta_channel
// One channel of the delta register bank: value register, change detect, sticky flag,
// saturating change counter and (with DELTA_REG_BANK_SNAPSHOT_EN) a pre-change snapshot.
// Ports:
//   CLK, RSTN  : clock, synchronous active-low reset
//   armed_i    : detection enable (low on the first cycle after reset)
//   mode_i     : detect mode for this channel
//   value_i    : live hardware value, loaded every cycle
//   clear_i    : this channel is being read this cycle; flag/count/snapshot clear
//   value_o    : registered value
//   flag_o     : sticky change flag
//   count_o    : saturating change count
//   snap_o     : value before the flag-setting change (snapshot build only)
module delta_channel
    import delta_reg_bank_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned COUNT_WIDTH = 8
) (
    input  logic                   CLK,
    input  logic                   RSTN,
    input  logic                   armed_i,
    input  mode_t                  mode_i,
    input  logic [DATA_WIDTH-1:0]  value_i,
    input  logic                   clear_i,
    output logic [DATA_WIDTH-1:0]  value_o,
    output logic                   flag_o,
    output logic [COUNT_WIDTH-1:0] count_o
`ifdef DELTA_REG_BANK_SNAPSHOT_EN
    ,
    output logic [DATA_WIDTH-1:0]  snap_o
`endif
);

    logic [DATA_WIDTH-1:0]  value_q;
    logic                   flag_q, flag_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic                   event_w;

    assign event_w = armed_i & detect_event(mode_i,
                                            |(value_i ^ value_q),
                                            |(value_i & ~value_q),
                                            |(~value_i & value_q));

    // A read clears the channel, but an event in the same cycle wins and restarts at 1.
    always_comb begin
        flag_d  = flag_q;
        count_d = count_q;
        if (clear_i) begin
            flag_d  = event_w;
            count_d = event_w ? COUNT_WIDTH'(1) : '0;
        end else if (event_w) begin
            flag_d = 1'b1;
            if (count_q != '1) begin
                count_d = count_q + COUNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            value_q <= '0;
            flag_q  <= 1'b0;
            count_q <= '0;
        end else begin
            value_q <= value_i;
            flag_q  <= flag_d;
            count_q <= count_d;
        end
    end

`ifdef DELTA_REG_BANK_SNAPSHOT_EN
    logic [DATA_WIDTH-1:0] snap_q, snap_d;

    // Capture only on the event that raises the flag; after a clear the flag is
    // considered clear, so a simultaneous event captures again.
    always_comb begin
        snap_d = snap_q;
        if (clear_i) begin
            snap_d = event_w ? value_q : '0;
        end else if (event_w && !flag_q) begin
            snap_d = value_q;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            snap_q <= '0;
        end else begin
            snap_q <= snap_d;
        end
    end

    assign snap_o = snap_q;
`endif

    assign value_o = value_q;
    assign flag_o  = flag_q;
    assign count_o = count_q;

endmodule

// File: rtl/delta_reg_bank.sv
// delta_reg_bank
// Bank of read-only change-detect status registers. Each channel samples VALUE_IN every
// cycle, flags and counts changes per its MODE, and is cleared when software reads it.
// Masked flags are OR-reduced into a registered level interrupt.
// Build option: define DELTA_REG_BANK_SNAPSHOT_EN to add per-channel snapshots and RPREV.
// Ports:
//   CLK, RSTN  : clock, synchronous active-low reset
//   VALUE_IN   : packed channel values, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   MODE       : 2 bits per channel, 00 any, 01 rise, 10 fall, 11 off
//   IRQ_MASK   : per-channel interrupt enable
//   READ_EN    : single-cycle read strobe, READ_SEL selects the channel
//   RVALID     : read response valid (one cycle after READ_EN)
//   RDATA      : channel register value, RFLAG / RCOUNT : pre-clear flag and count
//   RERR       : READ_SEL out of range
//   RPREV      : pre-change snapshot (snapshot build only)
//   FLAGS      : live sticky flags, IRQ : |(FLAGS & IRQ_MASK), registered
module delta_reg_bank
    import delta_reg_bank_pkg::*;
#(
    parameter int unsigned NUM_CHANNELS = 4,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned COUNT_WIDTH  = 8,
    parameter int unsigned SEL_WIDTH    = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic                             CLK,
    input  logic                             RSTN,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] VALUE_IN,
    input  logic [2*NUM_CHANNELS-1:0]        MODE,
    input  logic [NUM_CHANNELS-1:0]          IRQ_MASK,
    input  logic                             READ_EN,
    input  logic [SEL_WIDTH-1:0]             READ_SEL,
    output logic                             RVALID,
    output logic [DATA_WIDTH-1:0]            RDATA,
    output logic                             RFLAG,
    output logic [COUNT_WIDTH-1:0]           RCOUNT,
    output logic                             RERR,
`ifdef DELTA_REG_BANK_SNAPSHOT_EN
    output logic [DATA_WIDTH-1:0]            RPREV,
`endif
    output logic [NUM_CHANNELS-1:0]          FLAGS,
    output logic                             IRQ
);

    logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0]  value_w;
    logic [NUM_CHANNELS-1:0][COUNT_WIDTH-1:0] count_w;
    logic [NUM_CHANNELS-1:0]                  flags_w;
    logic [NUM_CHANNELS-1:0]                  clear_w;
    logic                                     armed_q;

    logic                   sel_hit;
    logic [DATA_WIDTH-1:0]  sel_data;
    logic                   sel_flag;
    logic [COUNT_WIDTH-1:0] sel_count;

    logic                   rvalid_q;
    logic [DATA_WIDTH-1:0]  rdata_q;
    logic                   rflag_q;
    logic [COUNT_WIDTH-1:0] rcount_q;
    logic                   rerr_q;
    logic                   irq_q;

`ifdef DELTA_REG_BANK_SNAPSHOT_EN
    logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0] snap_w;
    logic [DATA_WIDTH-1:0]                   sel_snap;
    logic [DATA_WIDTH-1:0]                   rprev_q;
`endif

    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_chan
        delta_channel #(
            .DATA_WIDTH  (DATA_WIDTH),
            .COUNT_WIDTH (COUNT_WIDTH)
        ) u_chan (
            .CLK     (CLK),
            .RSTN    (RSTN),
            .armed_i (armed_q),
            .mode_i  (mode_t'(MODE[2*g +: 2])),
            .value_i (VALUE_IN[g*DATA_WIDTH +: DATA_WIDTH]),
            .clear_i (clear_w[g]),
            .value_o (value_w[g]),
            .flag_o  (flags_w[g]),
            .count_o (count_w[g])
`ifdef DELTA_REG_BANK_SNAPSHOT_EN
            ,
            .snap_o  (snap_w[g])
`endif
        );
    end

    // Read mux; an unmatched select leaves all data at zero and raises no clear.
    always_comb begin
        sel_hit   = 1'b0;
        sel_data  = '0;
        sel_flag  = 1'b0;
        sel_count = '0;
        clear_w   = '0;
`ifdef DELTA_REG_BANK_SNAPSHOT_EN
        sel_snap  = '0;
`endif
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (READ_SEL == SEL_WIDTH'(i)) begin
                sel_hit    = 1'b1;
                sel_data   = value_w[i];
                sel_flag   = flags_w[i];
                sel_count  = count_w[i];
                clear_w[i] = READ_EN;
`ifdef DELTA_REG_BANK_SNAPSHOT_EN
                sel_snap   = snap_w[i];
`endif
            end
        end
    end

    // armed_q stays low for exactly the first edge after reset so the reset value of
    // the channel registers is never compared against live data.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            armed_q  <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rflag_q  <= 1'b0;
            rcount_q <= '0;
            rerr_q   <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            armed_q  <= 1'b1;
            rvalid_q <= READ_EN;
            irq_q    <= |(flags_w & IRQ_MASK);
            if (READ_EN) begin
                rdata_q  <= sel_data;
                rflag_q  <= sel_flag;
                rcount_q <= sel_count;
                rerr_q   <= ~sel_hit;
            end
        end
    end

`ifdef DELTA_REG_BANK_SNAPSHOT_EN
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            rprev_q <= '0;
        end else if (READ_EN) begin
            rprev_q <= sel_snap;
        end
    end

    assign RPREV = rprev_q;
`endif

    assign RVALID = rvalid_q;
    assign RDATA  = rdata_q;
    assign RFLAG  = rflag_q;
    assign RCOUNT = rcount_q;
    assign RERR   = rerr_q;
    assign FLAGS  = flags_w;
    assign IRQ    = irq_q;

endmodule

// File: tb/tb_delta_reg_bank.sv
// tb_delta_reg_bank
// Directed bench for delta_reg_bank with a cycle-level behavioural model of the bank
// (arrays of values/flags/counts) checked every cycle, plus literal expectations.
// Honours DELTA_REG_BANK_SNAPSHOT_EN when the design is built with it.
module tb_delta_reg_bank;
    import delta_reg_bank_pkg::*;

    localparam int NCH = 4;
    localparam int DW  = 32;
    localparam int CW  = 8;
    localparam int SW  = 3;  // wide enough to present out-of-range selects
    localparam int CMAX = (1 << CW) - 1;

    logic              CLK = 1'b0;
    logic              RSTN;
    logic [NCH*DW-1:0] VALUE_IN;
    logic [2*NCH-1:0]  MODE;
    logic [NCH-1:0]    IRQ_MASK;
    logic              READ_EN;
    logic [SW-1:0]     READ_SEL;
    logic              RVALID;
    logic [DW-1:0]     RDATA;
    logic              RFLAG;
    logic [CW-1:0]     RCOUNT;
    logic              RERR;
    logic [NCH-1:0]    FLAGS;
    logic              IRQ;
`ifdef DELTA_REG_BANK_SNAPSHOT_EN
    logic [DW-1:0]     RPREV;
`endif

    delta_reg_bank #(
        .NUM_CHANNELS (NCH),
        .DATA_WIDTH   (DW),
        .COUNT_WIDTH  (CW),
        .SEL_WIDTH    (SW)
    ) dut (
        .CLK      (CLK),
        .RSTN     (RSTN),
        .VALUE_IN (VALUE_IN),
        .MODE     (MODE),
        .IRQ_MASK (IRQ_MASK),
        .READ_EN  (READ_EN),
        .READ_SEL (READ_SEL),
        .RVALID   (RVALID),
        .RDATA    (RDATA),
        .RFLAG    (RFLAG),
        .RCOUNT   (RCOUNT),
        .RERR     (RERR),
`ifdef DELTA_REG_BANK_SNAPSHOT_EN
        .RPREV    (RPREV),
`endif
        .FLAGS    (FLAGS),
        .IRQ      (IRQ)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;
    bit check_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [DW-1:0] m_reg  [NCH];
    bit            m_flag [NCH];
    int            m_cnt  [NCH];
    logic [DW-1:0] m_prev [NCH];
    bit            m_armed  = 1'b0;
    bit            m_rvalid = 1'b0;
    bit            m_rerr   = 1'b0;
    bit            m_rflag  = 1'b0;
    bit            m_irq    = 1'b0;
    logic [DW-1:0] m_rdata  = '0;
    logic [DW-1:0] m_rprev  = '0;
    int            m_rcount = 0;

    function automatic logic [NCH-1:0] m_flags_vec();
        logic [NCH-1:0] f;
        for (int c = 0; c < NCH; c++) f[c] = m_flag[c];
        return f;
    endfunction

    always @(posedge CLK) begin
        bit            ev [NCH];
        logic [DW-1:0] v, r;
        int            sel;
        if (!RSTN) begin
            for (int c = 0; c < NCH; c++) begin
                m_reg[c] = '0; m_flag[c] = 0; m_cnt[c] = 0; m_prev[c] = '0;
            end
            m_armed = 0; m_rvalid = 0; m_rerr = 0; m_rflag = 0; m_irq = 0;
            m_rdata = '0; m_rprev = '0; m_rcount = 0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                v = VALUE_IN[c*DW +: DW];
                r = m_reg[c];
                case (MODE[2*c +: 2])
                    2'b00:   ev[c] = (v != r);
                    2'b01:   ev[c] = ((v & ~r) != 0);
                    2'b10:   ev[c] = ((~v & r) != 0);
                    default: ev[c] = 0;
                endcase
                ev[c] = ev[c] && m_armed;
            end
            sel = int'(READ_SEL);
            m_rvalid = READ_EN;
            if (READ_EN) begin
                if (sel < NCH) begin
                    m_rerr = 0; m_rdata = m_reg[sel]; m_rflag = m_flag[sel];
                    m_rcount = m_cnt[sel]; m_rprev = m_prev[sel];
                end else begin
                    m_rerr = 1; m_rdata = '0; m_rflag = 0; m_rcount = 0; m_rprev = '0;
                end
            end
            m_irq = ((m_flags_vec() & IRQ_MASK) != 0);
            for (int c = 0; c < NCH; c++) begin
                if (READ_EN && sel == c) begin
                    m_flag[c] = ev[c];
                    m_cnt[c]  = ev[c] ? 1 : 0;
                    m_prev[c] = ev[c] ? m_reg[c] : '0;
                end else if (ev[c]) begin
                    if (!m_flag[c]) m_prev[c] = m_reg[c];
                    m_flag[c] = 1;
                    if (m_cnt[c] < CMAX) m_cnt[c]++;
                end
                m_reg[c] = VALUE_IN[c*DW +: DW];
            end
            m_armed = 1;
        end
    end

    always @(negedge CLK) begin
        if (check_en) begin
            chk("model RVALID", RVALID, m_rvalid);
            chk("model FLAGS", FLAGS, m_flags_vec());
            chk("model IRQ", IRQ, m_irq);
            if (m_rvalid) begin
                chk("model RDATA", RDATA, m_rdata);
                chk("model RFLAG", RFLAG, m_rflag);
                chk("model RCOUNT", RCOUNT, 64'(m_rcount));
                chk("model RERR", RERR, m_rerr);
`ifdef DELTA_REG_BANK_SNAPSHOT_EN
                chk("model RPREV", RPREV, m_rprev);
`endif
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_ch(input int ch, input logic [DW-1:0] v);
        VALUE_IN[ch*DW +: DW] = v;
    endtask

    task automatic set_mode(input int ch, input logic [1:0] m);
        MODE[2*ch +: 2] = m;
    endtask

    task automatic read_ch(input int sel);
        READ_EN  = 1'b1;
        READ_SEL = SW'(sel);
        step();
        READ_EN  = 1'b0;
    endtask

    initial begin
        RSTN = 1'b0; READ_EN = 1'b0; READ_SEL = '0; MODE = '0; IRQ_MASK = 4'hF;
        VALUE_IN = '0;
        set_ch(0, 32'hA5);
        set_ch(1, 32'h0F);
        set_mode(1, MODE_RISE);
        step();
        check_en = 1'b1;
        step(); step();
        chk("reset RVALID", RVALID, 0);
        chk("reset FLAGS", FLAGS, 0);
        chk("reset IRQ", IRQ, 0);
        chk("reset RDATA", RDATA, 0);
        chk("reset RCOUNT", RCOUNT, 0);
        chk("reset RERR", RERR, 0);

        // Held value after reset must not register as a change.
        RSTN = 1'b1;
        repeat (4) step();
        chk("armed FLAGS", FLAGS, 0);
        chk("armed IRQ", IRQ, 0);
        read_ch(0);
        chk("rd0 RVALID", RVALID, 1);
        chk("rd0 RDATA", RDATA, 32'hA5);
        chk("rd0 RFLAG", RFLAG, 0);
        chk("rd0 RCOUNT", RCOUNT, 0);

        // Rise mode: 0F -> 1F -> 0F is one event.
        set_ch(1, 32'h1F);
        step();
        chk("rise FLAGS1", FLAGS[1], 1);
        set_ch(1, 32'h0F);
        step(); step();
        read_ch(1);
        chk("rise RFLAG", RFLAG, 1);
        chk("rise RCOUNT", RCOUNT, 1);
        chk("rise RDATA", RDATA, 32'h0F);
        chk("rise FLAGS1 clr", FLAGS[1], 0);

        // Counter saturation.
        for (int i = 0; i < 300; i++) begin
            set_ch(2, (i % 2 == 0) ? 32'h1 : 32'h0);
            step();
        end
        read_ch(2);
        chk("sat RCOUNT", RCOUNT, 255);
        chk("sat RFLAG", RFLAG, 1);
        chk("sat RDATA", RDATA, 0);

        // Read colliding with an event on the same channel.
        set_ch(3, 32'h5); step();
        set_ch(3, 32'h6); step();
        set_ch(3, 32'h7);
        read_ch(3);
        chk("coll RFLAG", RFLAG, 1);
        chk("coll RCOUNT", RCOUNT, 2);
        chk("coll RDATA", RDATA, 32'h6);
        chk("coll FLAGS3", FLAGS[3], 1);
        read_ch(3);
        chk("coll2 RCOUNT", RCOUNT, 1);
        chk("coll2 RDATA", RDATA, 32'h7);

        // IRQ masking and deassertion timing.
        IRQ_MASK = 4'b0100;
        set_ch(0, 32'hA4); step();
        set_ch(2, 32'h1);  step();
        step();
        chk("irq IRQ set", IRQ, 1);
        chk("irq FLAGS", FLAGS, 4'b0101);
        read_ch(2);
        chk("irq FLAGS clr", FLAGS, 4'b0001);
        chk("irq IRQ lag", IRQ, 1);
        step();
        chk("irq IRQ low", IRQ, 0);
        chk("irq FLAGS0", FLAGS[0], 1);

        // Out-of-range select.
        read_ch(5);
        chk("oor RVALID", RVALID, 1);
        chk("oor RERR", RERR, 1);
        chk("oor RDATA", RDATA, 0);
        chk("oor RCOUNT", RCOUNT, 0);
        chk("oor FLAGS", FLAGS, 4'b0001);

        // Snapshot sequence 10 -> 20 -> 30.
        read_ch(0);
        set_ch(0, 32'h10); step();
        read_ch(0);
        set_ch(0, 32'h20); step();
        set_ch(0, 32'h30); step();
        read_ch(0);
        chk("snap RDATA", RDATA, 32'h30);
        chk("snap RCOUNT", RCOUNT, 2);
`ifdef DELTA_REG_BANK_SNAPSHOT_EN
        chk("snap RPREV", RPREV, 32'h10);
`endif

        // Mode change takes effect on the same cycle's comparison.
        set_mode(1, MODE_OFF);
        set_ch(1, 32'hFF); step();
        chk("off FLAGS1", FLAGS[1], 0);
        set_mode(1, MODE_FALL);
        set_ch(1, 32'h0F); step();
        chk("fall FLAGS1", FLAGS[1], 1);

        // Back-to-back reads.
        READ_EN = 1'b1; READ_SEL = 3'd1; step();
        chk("b2b RCOUNT1", RCOUNT, 1);
        READ_SEL = 3'd0; step();
        chk("b2b RDATA0", RDATA, 32'h30);
        READ_SEL = 3'd1; step();
        chk("b2b RFLAG1", RFLAG, 0);
        READ_EN = 1'b0;

        // Reset mid-operation drops the pending response.
        set_ch(3, 32'h8); step();
        chk("pre-rst FLAGS3", FLAGS[3], 1);
        RSTN = 1'b0; READ_EN = 1'b1; READ_SEL = 3'd3; step();
        chk("rst RVALID", RVALID, 0);
        chk("rst FLAGS", FLAGS, 0);
        chk("rst IRQ", IRQ, 0);
        READ_EN = 1'b0; RSTN = 1'b1;
        repeat (3) step();
        chk("post-rst FLAGS", FLAGS, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
